pipeline_hazard_ctrl: RTL

Hazard and stall controller for the 5-stage pipeline. It drives the freeze/flush controls of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch redirects and multi-cycle data-memory accesses. It also keeps stall/flush performance counters and a sticky memory-timeout error.

---
 rtl/pipeline_hazard_ctrl_if.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX operand info and memory handshake in,
// pipeline-register freeze/flush controls, counters and error out.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic              mem_req;
  logic              mem_ready;
  logic              pc_freeze;
  logic              ifid_freeze;
  logic              idex_freeze;
  logic              exmem_freeze;
  logic              ifid_flush;
  logic              idex_flush;
  logic              memwb_flush;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_events;
  logic              mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_freeze, ifid_freeze, idex_freeze, exmem_freeze,
           ifid_flush, idex_flush, memwb_flush,
           stall_cycles, flush_events, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    output pc_freeze, ifid_freeze, idex_freeze, exmem_freeze,
           ifid_flush, idex_flush, memwb_flush,
           stall_cycles, flush_events, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: load-use bubbles, branch
// redirects, data-memory wait states with timeout, and performance counters.
//
//   state    | meaning
//   RUN      | normal issue; memstall > branch > load-use
//   MEM_WAIT | data memory busy, whole pipe frozen, wait cycles counted
//   ERROR    | memory timed out; pipe frozen until reset
module pipeline_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam logic [15:0]      TIMEOUT_V = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t      state, state_nx;
  logic [15:0] wait_cnt, wait_cnt_nx;
  logic        lu, memstall, flush_evt;
  logic        pc_fz, ifid_fz, idex_fz, exmem_fz;
  logic        ifid_fl, idex_fl, memwb_fl;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  assign lu = hz.ex_mem_read && (hz.ex_rd != '0) &&
              ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
               (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));
  assign memstall = hz.mem_req && !hz.mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (pc_fz && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // wait_cnt counts wait cycles already completed, including the RUN cycle
  // that first saw the stall, so TIMEOUT bounds the total freeze length.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    flush_evt   = 1'b0;
    pc_fz       = 1'b0;
    ifid_fz     = 1'b0;
    idex_fz     = 1'b0;
    exmem_fz    = 1'b0;
    ifid_fl     = 1'b0;
    idex_fl     = 1'b0;
    memwb_fl    = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (memstall) begin
            {pc_fz, ifid_fz, idex_fz, exmem_fz, memwb_fl} = 5'b11111;
            wait_cnt_nx = 16'd1;
            state_nx    = (TIMEOUT_V == 16'd1) ? ERROR : MEM_WAIT;
          end else begin
            wait_cnt_nx = '0;
            if (hz.ex_branch_taken) begin
              ifid_fl   = 1'b1;
              idex_fl   = 1'b1;
              flush_evt = 1'b1;
            end else if (lu) begin
              pc_fz   = 1'b1;
              ifid_fz = 1'b1;
              idex_fl = 1'b1;
            end
          end
        end
        MEM_WAIT: begin
          if (hz.mem_ready) begin
            state_nx    = RUN;
            wait_cnt_nx = '0;
          end else begin
            {pc_fz, ifid_fz, idex_fz, exmem_fz, memwb_fl} = 5'b11111;
            wait_cnt_nx = wait_cnt + 16'd1;
            if ((wait_cnt + 16'd1) >= TIMEOUT_V) state_nx = ERROR;
          end
        end
        ERROR: begin
          {pc_fz, ifid_fz, idex_fz, exmem_fz, memwb_fl} = 5'b11111;
        end
        default: begin
          state_nx    = RUN;
          wait_cnt_nx = '0;
        end
      endcase
    end
  end

  assign hz.pc_freeze    = pc_fz;
  assign hz.ifid_freeze  = ifid_fz;
  assign hz.idex_freeze  = idex_fz;
  assign hz.exmem_freeze = exmem_fz;
  assign hz.ifid_flush   = ifid_fl;
  assign hz.idex_flush   = idex_fl;
  assign hz.memwb_flush  = memwb_fl;
  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_events = flush_cnt;
  assign hz.mem_timeout  = (state == ERROR);

endmodule
